// File: rtl/alu_issuer.sv
// Single-outstanding issuer for R-type ALU operations: decodes a request, drives
// the ALU for exactly one cycle, then holds the captured result until it is consumed.
module alu_issuer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [31:0]      req_rs,
  input  logic [31:0]      req_rt,
  input  logic [4:0]       req_shamt,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  input  logic [31:0]      alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             err_q, err_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [2:0]  dec_op;
  logic        dec_err;

  // Variable shifts use only rs[4:0], so the ALU never sees a shift of 32 or more.
  always_comb begin
    dec_a   = req_rs;
    dec_b   = req_rt;
    dec_op  = 3'b000;
    dec_err = 1'b0;
    case (req_funct)
      6'h20: dec_op = 3'b000;
      6'h22: dec_op = 3'b001;
      6'h24: dec_op = 3'b010;
      6'h25: dec_op = 3'b011;
      6'h02: begin dec_op = 3'b100; dec_a = req_rt; dec_b = {27'b0, req_shamt}; end
      6'h03: begin dec_op = 3'b101; dec_a = req_rt; dec_b = {27'b0, req_shamt}; end
      6'h06: begin dec_op = 3'b100; dec_a = req_rt; dec_b = {27'b0, req_rs[4:0]}; end
      6'h07: begin dec_op = 3'b101; dec_a = req_rt; dec_b = {27'b0, req_rs[4:0]}; end
      default: begin dec_op = 3'b111; dec_a = 32'b0; dec_b = 32'b0; dec_err = 1'b1; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    alu_a_d    = 32'b0;
    alu_b_d    = 32'b0;
    alu_op_d   = 3'b000;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d  = ISSUE;
          alu_a_d  = dec_a;
          alu_b_d  = dec_b;
          alu_op_d = dec_op;
          err_d    = dec_err;
          cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ISSUE: begin
        state_d    = RESP;
        rsp_data_d = err_q ? 32'b0 : alu_c;
        rsp_err_d  = err_q;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags are registered copies of the next state.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      alu_a_q     <= 32'b0;
      alu_b_q     <= 32'b0;
      alu_op_q    <= 3'b000;
      err_q       <= 1'b0;
      rsp_data_q  <= 32'b0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      err_q       <= err_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a behavioural ALU on alu_a/alu_b/alu_op -> alu_c.
// A 4-bit counter is used so the op_count wrap is reachable quickly.
module tb_alu_issuer;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [5:0]    req_funct;
  logic [31:0]   req_rs, req_rt;
  logic [4:0]    req_shamt;
  logic [31:0]   alu_a, alu_b, alu_c;
  logic [2:0]    alu_op;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic [CW-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_cnt;

  alu_issuer #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct(req_funct), .req_rs(req_rs), .req_rt(req_rt), .req_shamt(req_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_c = 32'b0;
    case (alu_op)
      3'b000: alu_c = alu_a + alu_b;
      3'b001: alu_c = alu_a - alu_b;
      3'b010: alu_c = alu_a & alu_b;
      3'b011: alu_c = alu_a | alu_b;
      3'b100: alu_c = alu_a >> alu_b[4:0];
      3'b101: alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_c = 32'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents a request in IDLE and returns #1 after the accepting edge (in ISSUE),
  // with the request inputs scrambled to show they are ignored.
  task automatic launch(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] sh);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_funct = f; req_rs = rs; req_rt = rt; req_shamt = sh; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_funct = 6'h22; req_rs = ~rs; req_rt = ~rt; req_shamt = ~sh;
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic txn(input string name, input logic [5:0] f, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [4:0] sh, input logic [2:0] e_op,
                     input logic [31:0] e_a, input logic [31:0] e_b,
                     input logic [31:0] e_data, input logic e_err);
    launch(f, rs, rt, sh);
    check({name, "_op"}, {29'b0, alu_op}, {29'b0, e_op});
    check({name, "_a"}, alu_a, e_a);
    check({name, "_b"}, alu_b, e_b);
    check({name, "_busy"}, {30'b0, req_ready, rsp_valid}, 32'd0);
    check({name, "_cnt"}, {28'b0, op_count}, {28'b0, exp_cnt});
    @(posedge clk); #1;
    check({name, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({name, "_data"}, rsp_data, e_data);
    check({name, "_err"}, {31'b0, rsp_err}, {31'b0, e_err});
    check({name, "_alu_idle"}, {alu_a | alu_b, 29'b0, alu_op}, 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({name, "_done"}, {30'b0, req_ready, rsp_valid}, 32'd2);
    $display("txn %s funct=%02h data=%08h err=%0d cnt=%0d", name, f, rsp_data, rsp_err, op_count);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_funct = 6'h0; req_rs = 32'h0; req_rt = 32'h0; req_shamt = 5'h0;
    exp_cnt = '0;
    #12;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_outs", {alu_a | alu_b | rsp_data}, 32'd0);
    check("rst_flags", {24'b0, alu_op, rsp_valid, rsp_err, 1'b0, 2'b0}, 32'd0);
    check("rst_cnt", {28'b0, op_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    txn("add_ovf", 6'h20, 32'h7FFF_FFFF, 32'h1,        5'd0,  3'b000, 32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 1'b0);
    txn("sub",     6'h22, 32'd5,         32'd7,        5'd0,  3'b001, 32'd5,         32'd7,  32'hFFFF_FFFE, 1'b0);
    txn("and",     6'h24, 32'hF0F0_FFFF, 32'h0FF0_00FF, 5'd0, 3'b010, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h00F0_00FF, 1'b0);
    txn("or",      6'h25, 32'hF000_0000, 32'h0000_000F, 5'd0, 3'b011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0);
    txn("srl31",   6'h02, 32'h1234_5678, 32'h8000_0000, 5'd31, 3'b100, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0);
    txn("sra4",    6'h03, 32'h0,         32'h8000_0000, 5'd4, 3'b101, 32'h8000_0000, 32'd4,  32'hF800_0000, 1'b0);
    txn("srlv",    6'h06, 32'h0000_0024, 32'hFFFF_FFFF, 5'd9, 3'b100, 32'hFFFF_FFFF, 32'd4,  32'h0FFF_FFFF, 1'b0);
    txn("srav",    6'h07, 32'h0000_003F, 32'h8000_0000, 5'd0, 3'b101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
    txn("unsup",   6'h18, 32'd5,         32'd6,        5'd3,  3'b111, 32'h0,         32'h0,  32'h0,         1'b1);

    // Backpressure: response held for 5 cycles.
    launch(6'h20, 32'd3, 32'd4, 5'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_data", rsp_data, 32'd7);
      check("bp_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_release", {30'b0, req_ready, rsp_valid}, 32'd2);
    $display("txn backpressure data=%08h cnt=%0d", rsp_data, op_count);

    // Reset mid-ISSUE aborts the transaction.
    launch(6'h25, 32'hAAAA_0000, 32'h0000_5555, 5'd0);
    check("mid_op", {29'b0, alu_op}, 32'd3);
    rst_n = 1'b0;
    #2;
    check("mid_rst_a", alu_a, 32'd0);
    check("mid_rst_b", alu_b, 32'd0);
    check("mid_rst_op", {29'b0, alu_op}, 32'd0);
    check("mid_rst_cnt", {28'b0, op_count}, 32'd0);
    check("mid_rst_hs", {30'b0, req_ready, rsp_valid}, 32'd2);
    exp_cnt = '0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    $display("txn reset_mid_issue cnt=%0d", op_count);

    // Walk the counter to all-ones, then one more acceptance wraps it.
    for (int i = 0; i < 15; i++)
      txn("fill", 6'h20, i, 32'd1, 5'd0, 3'b000, i, 32'd1, i + 1, 1'b0);
    check("cnt_ones", {28'b0, op_count}, 32'd15);
    txn("wrap", 6'h22, 32'd0, 32'd1, 5'd0, 3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    check("cnt_wrap", {28'b0, op_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
